// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - in-order instruction fetch with request credit, PC tracking and decode FIFO
module instruction_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h00400000,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic [31:0] fetch_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
  logic [31:0]       fifo_instr_q [DEPTH], fifo_instr_d [DEPTH];
  logic [31:0]       fifo_pc_q    [DEPTH], fifo_pc_d    [DEPTH];
  logic [31:0]       pq_pc_q      [DEPTH], pq_pc_d      [DEPTH];

  logic credit_ok, fire, rv, push, pop;

  // Sum is one bit wider than the counters so outstanding + count never wraps.
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, count_q}) < (CW+1)'(DEPTH);
  assign imem_req  = (state_q == FETCH) & credit_ok & ~halt & ~redirect;
  assign imem_addr = fetch_pc_q;
  assign fetch_pc  = fetch_pc_q;
  assign fire      = imem_req & imem_gnt;
  assign rv        = imem_rvalid & (outstanding_q != '0);
  assign push      = rv & (state_q == FETCH) & ~redirect;
  assign pop       = (count_q != '0) & if_ready;
  assign if_valid  = (count_q != '0);
  assign if_instr  = fifo_instr_q[rd_ptr_q];
  assign if_pc     = fifo_pc_q[rd_ptr_q];

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    pq_wr_d       = pq_wr_q;
    pq_rd_d       = pq_rd_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_pc_d     = fifo_pc_q;
    pq_pc_d       = pq_pc_q;
    outstanding_d = outstanding_q + CW'(fire) - CW'(rv);
    count_d       = count_q + CW'(push) - CW'(pop);

    if (fire) begin
      fetch_pc_d       = fetch_pc_q + 32'd4;
      pq_pc_d[pq_wr_q] = fetch_pc_q;
      pq_wr_d          = pq_wr_q + 1'b1;
    end
    if (push) begin
      fifo_instr_d[wr_ptr_q] = imem_rdata;
      fifo_pc_d[wr_ptr_q]    = pq_pc_q[pq_rd_q];
      wr_ptr_d               = wr_ptr_q + 1'b1;
      pq_rd_d                = pq_rd_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (state_q == DRAIN && outstanding_d == '0) begin
      state_d = FETCH;
    end

    // Responses still owed to the old path are dropped in DRAIN, so the PC queue restarts empty.
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      pq_wr_d    = '0;
      pq_rd_d    = '0;
      state_d    = (outstanding_d == '0) ? FETCH : DRAIN;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pq_wr_q       <= '0;
      pq_rd_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pq_wr_q       <= pq_wr_d;
      pq_rd_q       <= pq_rd_d;
    end
  end

  always_ff @(posedge clock) begin
    fifo_instr_q <= fifo_instr_d;
    fifo_pc_q    <= fifo_pc_d;
    pq_pc_q      <= pq_pc_d;
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - directed bench with memory responder model and decode scoreboard
module tb_instruction_fetch_queue;

  localparam logic [31:0] RPC = 32'h00400000;

  logic        clock = 1'b0;
  logic        reset, halt, redirect, imem_gnt, imem_rvalid, if_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_instr, if_pc, fetch_pc;

  always #5 clock = ~clock;

  instruction_fetch_queue dut (
    .clock(clock), .reset(reset), .halt(halt), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .fetch_pc(fetch_pc)
  );

  typedef struct {logic [31:0] addr; bit drop; int age;} pend_t;
  typedef struct {logic [31:0] instr; logic [31:0] pc;} ent_t;

  pend_t       pending [$];
  ent_t        exp_q   [$];
  logic [31:0] issued  [$];
  int          n_cmp = 0, n_bad = 0, pops = 0;
  bit          gnt_en, resp_en, last_req, got_pop;
  logic [31:0] last_addr, first_pop_pc;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h13579bdf;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: entered and left at the falling edge with the next inputs already set.
  task automatic cycle();
    pend_t p;
    ent_t  e;
    imem_gnt    = gnt_en;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    #1;
    chk("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
    if (if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 32'(if_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("if_pc", if_pc, e.pc);
        chk("if_instr", if_instr, e.instr);
        pops++;
        if (!got_pop) begin
          first_pop_pc = if_pc;
          got_pop      = 1'b1;
        end
      end
    end
    last_req  = imem_req;
    last_addr = imem_addr;
    if (resp_en && pending.size() > 0 && pending[0].age >= 1) begin
      p           = pending.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(p.addr);
      if (!p.drop && !redirect && reset) exp_q.push_back('{mem_word(p.addr), p.addr});
    end
    if (imem_req && imem_gnt && reset) begin
      issued.push_back(imem_addr);
      pending.push_back('{imem_addr, 1'b0, 0});
    end
    if (redirect) begin
      foreach (pending[i]) pending[i].drop = 1'b1;
      exp_q.delete();
    end
    if (!reset) begin
      pending.delete();
      exp_q.delete();
    end
    @(posedge clock);
    foreach (pending[i]) pending[i].age++;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0; gnt_en = 1'b0; resp_en = 1'b0; redirect = 1'b0; halt = 1'b0;
    cycle();
    reset = 1'b1;
    issued.delete();
    pops = 0;
    got_pop = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; gnt_en = 1'b0; resp_en = 1'b0;
    @(negedge clock);
    cycle();
    cycle();
    reset = 1'b1;
    #1;
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_fetch_pc", fetch_pc, RPC);
    chk("rst_req", 32'(imem_req), 32'd1);
    halt = 1'b1;
    #1;
    chk("rst_req_halt", 32'(imem_req), 32'd0);
    halt = 1'b0;
    @(negedge clock);

    // Streaming with immediate grant and one-cycle response
    do_reset();
    gnt_en = 1'b1; resp_en = 1'b1; if_ready = 1'b1;
    repeat (12) cycle();
    for (int i = 0; i < 8; i++) chk("stream_addr", issued[i], RPC + 32'(4 * i));
    chk("stream_pops", 32'(pops >= 6), 32'd1);

    // Decode stalled: credit caps the number of requests
    do_reset();
    if_ready = 1'b0; gnt_en = 1'b1; resp_en = 1'b1;
    repeat (10) cycle();
    chk("full_issued", 32'(issued.size()), 32'd4);
    chk("full_req", 32'(last_req), 32'd0);
    chk("full_valid", 32'(if_valid), 32'd1);
    chk("full_head_pc", if_pc, RPC);
    if_ready = 1'b1;
    repeat (6) cycle();
    chk("full_resume", 32'(issued.size() > 4), 32'd1);

    // Grant withheld: address holds steady
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_req", 32'(last_req), 32'd1);
      chk("stall_addr", last_addr, RPC);
    end
    gnt_en = 1'b1;
    cycle();
    gnt_en = 1'b0;
    cycle();
    chk("stall_granted", issued[0], RPC);
    chk("stall_next_addr", last_addr, RPC + 32'd4);

    // Redirect with two outstanding and one buffered
    do_reset();
    if_ready = 1'b0; gnt_en = 1'b1; resp_en = 1'b1;
    cycle();
    cycle();
    resp_en = 1'b0;
    cycle();
    chk("redir_pre_valid", 32'(if_valid), 32'd1);
    chk("redir_pre_issued", 32'(issued.size()), 32'd3);
    gnt_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h00400100;
    cycle();
    redirect = 1'b0;
    chk("redir_flushed", 32'(if_valid), 32'd0);
    chk("redir_fetch_pc", fetch_pc, 32'h00400100);
    gnt_en = 1'b1; resp_en = 1'b1;
    cycle();
    chk("drain_req0", 32'(last_req), 32'd0);
    cycle();
    chk("drain_req1", 32'(last_req), 32'd0);
    if_ready = 1'b1;
    repeat (6) cycle();
    chk("redir_new_addr", issued[3], 32'h00400100);
    chk("redir_got_pop", 32'(got_pop), 32'd1);
    chk("redir_first_pc", first_pop_pc, 32'h00400100);

    // Halt stops requests but not responses or pops
    do_reset();
    gnt_en = 1'b1; resp_en = 1'b1; if_ready = 1'b1;
    cycle();
    cycle();
    n = issued.size();
    pops = 0;
    halt = 1'b1;
    repeat (5) cycle();
    chk("halt_no_req", 32'(issued.size()), 32'(n));
    chk("halt_pops", 32'(pops), 32'd2);
    chk("halt_req_low", 32'(last_req), 32'd0);
    halt = 1'b0;
    repeat (4) cycle();
    chk("halt_resume", 32'(issued.size() > n), 32'd1);

    // Reset mid-stream with three outstanding
    do_reset();
    gnt_en = 1'b1; resp_en = 1'b0; if_ready = 1'b1;
    repeat (3) cycle();
    chk("mid_issued", 32'(issued.size()), 32'd3);
    reset = 1'b0; gnt_en = 1'b0;
    cycle();
    reset = 1'b1;
    chk("mid_if_valid", 32'(if_valid), 32'd0);
    chk("mid_fetch_pc", fetch_pc, RPC);
    issued.delete();
    gnt_en = 1'b1;
    repeat (6) cycle();
    chk("mid_credit", 32'(issued.size()), 32'd4);

    // Fetch PC wraps at the top of the address space
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFFFFF8;
    cycle();
    redirect = 1'b0; gnt_en = 1'b1; resp_en = 1'b1; if_ready = 1'b1;
    repeat (6) cycle();
    chk("wrap0", issued[0], 32'hFFFFFFF8);
    chk("wrap1", issued[1], 32'hFFFFFFFC);
    chk("wrap2", issued[2], 32'h00000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
